// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter: LeftShifted_A = A << B, and 0 when B > 31. One shift-amount bit is applied per cycle.
// Latency: 5 cycles from the accepting edge to done. With LSHIFT_EARLY_EXIT_EN defined it is 1 + index of the highest set amount bit (1 when the amount is 0).
// Backpressure: start is accepted only while busy=0 and ignored otherwise. done is a one-cycle pulse, and the result is held until the next done.
module seq_left_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] LeftShifted_A
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       amt_q, amt_d;
  logic [2:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] shifted;
  logic             last_step;
  logic             b_too_big;

  // Amounts of 32 or more flush everything, so the full B word is compared, not just B[4:0].
  assign b_too_big = (B > WIDTH'(31));

  // Apply the current step's power-of-two shift when its amount bit is set.
  always_comb begin
    shifted = acc_q;
    if (amt_q[step_q]) begin
      case (step_q)
        3'd0:    shifted = acc_q << 1;
        3'd1:    shifted = acc_q << 2;
        3'd2:    shifted = acc_q << 4;
        3'd3:    shifted = acc_q << 8;
        3'd4:    shifted = acc_q << 16;
        default: shifted = acc_q;
      endcase
    end
  end

  // Decide whether this SHIFT edge is the one that terminates the operation.
  always_comb begin
`ifdef LSHIFT_EARLY_EXIT_EN
    // Stop as soon as no higher amount bits remain; step 4 always satisfies this.
    last_step = ((amt_q >> (step_q + 3'd1)) == 5'd0);
`else
    last_step = (step_q == 3'd4);
`endif
  end

  // Next-state and datapath control for the IDLE/SHIFT machine.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = b_too_big ? '0 : A;
          amt_d   = b_too_big ? 5'd0 : B[4:0];
          step_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = shifted;
        step_d = step_q + 3'd1;
        if (last_step) begin
          res_d   = shifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset wins over start and over any step in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= 5'd0;
      step_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign LeftShifted_A = res_q;

endmodule

// File: doc/seq_left_shifter.md
# seq_left_shifter

Multi-cycle logical left shifter for the RISC_KGP ALU shift path. It is the left-direction counterpart of the combinational right-shift unit. It accepts a 32-bit operand A and a 32-bit shift amount B, and produces A << B. Any B greater than 31 yields 0. The shift is computed iteratively, one bit of the 5-bit shift amount per cycle, and the result is returned through a start/busy/done handshake. The control unit uses it where a single-cycle 32-bit barrel shifter does not meet timing.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported; the shift amount is fixed at 5 bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request strobe; sampled only while busy=0.
- A, input, 32: operand to shift; sampled with start.
- B, input, 32: shift amount, unsigned; sampled with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when result becomes valid.
- LeftShifted_A, output, 32: result register; holds its value until the next done.

## Operation
- State machine with two states: IDLE and SHIFT.
- IDLE, start=1 at an edge:
  - acc <= (B > 31) ? 0 : A.
  - amt <= (B > 31) ? 0 : B[4:0].
  - step <= 0, busy <= 1, state -> SHIFT.
- IDLE, start=0: no state change; done=0.
- SHIFT, at each edge for step k (0..4):
  - If amt[k]=1, acc <= acc << 2^k; vacated bits fill with 0 and bits shifted past bit 31 are discarded.
  - If amt[k]=0, acc is unchanged.
  - step increments.
- Termination edge, which is the step-4 edge or the early exit described under Configuration:
  - LeftShifted_A <= final acc value.
  - done <= 1 and busy <= 0; state -> IDLE.
- start while busy=1: ignored; A and B are not sampled.
- The B > 31 comparison covers the full 32 bits. For example, B=32 gives 0, and B=0xFFFFFFFF gives 0.
- done is high for exactly one cycle per accepted start.

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, LeftShifted_A=0, acc=0, amt=0, step=0.
- rst has priority over start and over any in-progress step.
- Reset mid-operation aborts the operation with no done pulse. The outputs take their reset values at that edge.
- Latency (default build): start sampled at edge E0. busy=1 during cycles after E0..E4. Result and done appear after E5, giving a fixed 5-cycle latency.
- Back-to-back operation: start may be asserted in the cycle where done=1, because busy is already 0. It is accepted at the next edge, giving a throughput of one operation per 6 cycles.
- done and LeftShifted_A change on the same edge.
- busy falls on that same edge.

## Configuration
- Macro: LSHIFT_EARLY_EXIT_EN.
- Defined:
  - SHIFT terminates at the step-k edge when amt bits above k are all zero, i.e. (amt >> (k+1)) == 0.
  - Latency = 1 + index of the highest set bit of amt, or 1 when amt=0. This includes every B > 31 case, because amt is forced to 0.
  - The result is bit-identical to the default build.
- Not defined: fixed 5-cycle latency for every input, including B=0 and B > 31.

## Test plan
- Reset: hold rst 2 cycles mid-operation (A=0x1, B=7, after 2 SHIFT cycles) -> busy=0, done=0, LeftShifted_A=0, and no done pulse afterwards.
- Basic shift: A=0x0000_00F1, B=4 -> LeftShifted_A=0x0000_0F10 with done after exactly 5 edges. With LSHIFT_EARLY_EXIT_EN defined, done comes after 3 edges.
- Boundary amounts:
  - A=0x8000_0001, B=0 -> 0x8000_0001.
  - B=31 -> 0x8000_0000.
  - B=32 -> 0x0000_0000.
  - B=0xFFFF_FFFF -> 0x0000_0000.
  - With early exit, B=0 and B=32 both finish in 1 edge.
- Handshake: pulse start again while busy=1 with A=0xDEAD_BEEF, B=1 -> ignored, and the first result is unaffected. Then assert start during the done cycle with A=0x3, B=30 -> accepted, giving 0xC000_0000 and a second single-cycle done.
- Randomized sweep of 1000 A/B pairs, with B drawn from 0..40 plus random 32-bit values -> each result equals (B > 31 ? 0 : A << B), one done per accepted start. Run in both macro builds.
